// File: rtl/otp_decoder_if.sv
// rtl/otp_decoder_if.sv - ciphertext-in / plaintext-out handshake bundle for otp_decoder
// The slave side is the decoder; the master side feeds ciphertext and drains plaintext.
interface otp_decoder_if;
  logic       seed_load;
  logic [7:0] seed;
  logic       ct_valid;
  logic       ct_bit;
  logic       ct_last;
  logic       ct_ready;
  logic [7:0] pt_byte;
  logic [3:0] pt_nbits;
  logic       pt_last;
  logic       pt_valid;
  logic       pt_ready;
  logic       seed_err;

  modport master (
    output seed_load, seed, ct_valid, ct_bit, ct_last, pt_ready,
    input  ct_ready, pt_byte, pt_nbits, pt_last, pt_valid, seed_err
  );

  modport slave (
    input  seed_load, seed, ct_valid, ct_bit, ct_last, pt_ready,
    output ct_ready, pt_byte, pt_nbits, pt_last, pt_valid, seed_err
  );
endinterface

// File: rtl/otp_decoder.sv
// rtl/otp_decoder.sv - bit-serial LFSR keystream decoder packing plaintext into bytes
// One ciphertext bit per accepted beat; full or frame-final bytes go out through a 1-deep buffer.
module otp_decoder #(
  parameter logic [7:0] TAPS = 8'hB8
) (
  input  logic          clk,
  input  logic          rst,
  otp_decoder_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [6:0] shreg;
  logic [2:0] cnt;
  logic [7:0] pt_byte_q;
  logic [3:0] pt_nbits_q;
  logic       pt_last_q;
  logic       pt_valid_q;
  logic       seed_err_q;

  logic       ready;
  logic       accept;
  logic       p;
  logic       byte_done;
  logic [7:0] assembled;
  logic [7:0] aligned;

  // A held output byte blocks input so that no decoded bit can be overwritten.
  assign ready     = !rst && (state == RUN) && !bus.seed_load && (!pt_valid_q || bus.pt_ready);
  assign accept    = bus.ct_valid && ready;
  assign p         = bus.ct_bit ^ lfsr[7];
  assign byte_done = (cnt == 3'd7) || bus.ct_last;
  assign assembled = {shreg, p};
  // Partial bytes are shifted up so the first received bit lands in bit 7.
  assign aligned   = assembled << (3'd7 - cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= 8'h00;
      shreg      <= 7'h00;
      cnt        <= 3'd0;
      pt_byte_q  <= 8'h00;
      pt_nbits_q <= 4'd0;
      pt_last_q  <= 1'b0;
      pt_valid_q <= 1'b0;
      seed_err_q <= 1'b0;
    end else if (bus.seed_load) begin
      state      <= RUN;
      lfsr       <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
      shreg      <= 7'h00;
      cnt        <= 3'd0;
      pt_valid_q <= 1'b0;
      seed_err_q <= (bus.seed == 8'h00);
    end else begin
      if (pt_valid_q && bus.pt_ready) begin
        pt_valid_q <= 1'b0;
      end
      if (accept) begin
        lfsr <= {lfsr[6:0], ^(lfsr & TAPS)};
        if (byte_done) begin
          pt_byte_q  <= aligned;
          pt_nbits_q <= {1'b0, cnt} + 4'd1;
          pt_last_q  <= bus.ct_last;
          pt_valid_q <= 1'b1;
          shreg      <= 7'h00;
          cnt        <= 3'd0;
        end else begin
          shreg <= assembled[6:0];
          cnt   <= cnt + 3'd1;
        end
        if (bus.ct_last) begin
          state <= IDLE;
        end
      end
    end
  end

  assign bus.ct_ready = ready;
  assign bus.pt_byte  = pt_byte_q;
  assign bus.pt_nbits = pt_nbits_q;
  assign bus.pt_last  = pt_last_q;
  assign bus.pt_valid = pt_valid_q;
  assign bus.seed_err = seed_err_q;

endmodule

// File: tb/tb_otp_decoder.sv
// tb/tb_otp_decoder.sv - self-checking bench for otp_decoder
// Known-answer table, hand-written corner sequences and randomized frames against a keystream model.
module tb_otp_decoder;

  logic clk = 1'b0;
  logic rst;

  otp_decoder_if bus ();

  otp_decoder #(.TAPS(8'hB8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [3:0] nb;
    logic       last;
  } out_t;

  typedef struct {
    logic [7:0]  seed;
    logic [31:0] ctv;
    int          len;
    int          nout;
    logic [7:0]  b0;
    logic [3:0]  nb0;
    logic [7:0]  b1;
    logic [3:0]  nb1;
  } vec_t;

  int   tests  = 0;
  int   errors = 0;
  out_t got_q[$];
  out_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ct_ready"}, {31'd0, bus.ct_ready}, 32'd0);
    chk({tag, "_pt_valid"}, {31'd0, bus.pt_valid}, 32'd0);
    chk({tag, "_pt_byte"},  {24'd0, bus.pt_byte},  32'd0);
    chk({tag, "_pt_nbits"}, {28'd0, bus.pt_nbits}, 32'd0);
    chk({tag, "_pt_last"},  {31'd0, bus.pt_last},  32'd0);
    chk({tag, "_seed_err"}, {31'd0, bus.seed_err}, 32'd0);
  endtask

  // Reference: keystream bit i is the MSB of the LFSR after i steps; plaintext bit i
  // belongs to byte i/8 at position 7-(i%8); the last byte carries len-8*k bits.
  task automatic model(input logic [7:0] sd, input logic [31:0] ctv, input int len);
    logic [7:0] l;
    logic       ks[32];
    int         nbytes;
    l = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < 32; i++) begin
      ks[i] = l[7];
      l = {l[6:0], ^(l & 8'hB8)};
    end
    exp_q.delete();
    nbytes = (len + 7) / 8;
    for (int k = 0; k < nbytes; k++) begin
      out_t o;
      o.b    = 8'h00;
      o.nb   = 4'((len - 8 * k) > 8 ? 8 : (len - 8 * k));
      o.last = (k == nbytes - 1);
      for (int j = 0; j < int'(o.nb); j++) begin
        o.b[7 - j] = ctv[31 - (8 * k + j)] ^ ks[8 * k + j];
      end
      exp_q.push_back(o);
    end
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, {19'd0, got_q[i].b, got_q[i].nb, got_q[i].last},
                          {19'd0, exp_q[i].b, exp_q[i].nb, exp_q[i].last});
    end
  endtask

  // mode 0: pt_ready always high; 1: 10-cycle stall at first pt_valid; 2: random pt_ready
  task automatic run_frame(input logic [7:0] sd, input logic [31:0] ctv, input int len,
                           input int mode, input bit gaps, input string tag);
    int   idx;
    int   stall_left;
    bit   stalled_once;
    bit   done;
    bit   accepted;
    bit   prev_hold;
    out_t prev;
    got_q.delete();
    bus.seed_load = 1'b1;
    bus.seed      = sd;
    bus.ct_valid  = 1'b1;
    bus.ct_bit    = 1'b1;
    bus.ct_last   = 1'b0;
    bus.pt_ready  = 1'b1;
    @(negedge clk);
    chk({tag, "_seed_blocks_ct"}, {31'd0, bus.ct_ready}, 32'd0);
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    chk({tag, "_seed_err"}, {31'd0, bus.seed_err}, {31'd0, sd == 8'h00});
    chk({tag, "_seed_clears_valid"}, {31'd0, bus.pt_valid}, 32'd0);
    idx = 0; stall_left = 0; stalled_once = 0; done = 0; prev_hold = 0;
    prev = '{b: 8'h00, nb: 4'd0, last: 1'b0};
    for (int c = 0; c < 3000; c++) begin
      if (idx == len && !bus.pt_valid) begin
        done = 1;
        break;
      end
      bus.ct_valid = (idx < len) && (!gaps || $urandom_range(0, 3) != 0);
      bus.ct_bit   = (idx < len) ? ctv[31 - idx] : 1'b0;
      bus.ct_last  = (idx == len - 1);
      case (mode)
        1: begin
          if (bus.pt_valid && !stalled_once) begin
            stalled_once = 1;
            stall_left   = 10;
          end
          bus.pt_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        2:       bus.pt_ready = 1'($urandom_range(0, 1));
        default: bus.pt_ready = 1'b1;
      endcase
      @(negedge clk);
      if (prev_hold) begin
        chk({tag, "_hold_valid"}, {31'd0, bus.pt_valid}, 32'd1);
        chk({tag, "_hold_data"}, {19'd0, bus.pt_byte, bus.pt_nbits, bus.pt_last},
                                 {19'd0, prev.b, prev.nb, prev.last});
      end
      prev_hold = bus.pt_valid && !bus.pt_ready;
      prev = '{b: bus.pt_byte, nb: bus.pt_nbits, last: bus.pt_last};
      if (prev_hold) chk({tag, "_stall_ct_ready"}, {31'd0, bus.ct_ready}, 32'd0);
      if (bus.pt_valid && bus.pt_ready) got_q.push_back(prev);
      accepted = bus.ct_valid && bus.ct_ready;
      @(posedge clk); #1;
      if (accepted) idx++;
    end
    if (!done) chk({tag, "_frame_timeout"}, 32'd0, 32'd1);
    bus.ct_valid = 1'b1;
    bus.ct_last  = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after_last"}, {31'd0, bus.ct_ready}, 32'd0);
    @(posedge clk); #1;
    bus.ct_valid = 1'b0;
  endtask

  task automatic feed_bits(input logic [31:0] ctv, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ct_valid = 1'b1;
      bus.ct_bit   = ctv[31 - i];
      bus.ct_last  = 1'b0;
      @(negedge clk);
      chk("feed_ct_ready", {31'd0, bus.ct_ready}, 32'd1);
      @(posedge clk); #1;
    end
    bus.ct_valid = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{seed: 8'hFF, ctv: 32'hB76E0000, len: 16, nout: 2, b0: 8'h48, nb0: 4'd8, b1: 8'h65, nb1: 4'd8};
    vecs[1] = '{seed: 8'hFF, ctv: 32'h40000000, len: 3,  nout: 1, b0: 8'hA0, nb0: 4'd3, b1: 8'h00, nb1: 4'd0};
    vecs[2] = '{seed: 8'h00, ctv: 32'h49000000, len: 8,  nout: 1, b0: 8'h48, nb0: 4'd8, b1: 8'h00, nb1: 4'd0};
    vecs[3] = '{seed: 8'hFF, ctv: 32'hB7600000, len: 12, nout: 2, b0: 8'h48, nb0: 4'd8, b1: 8'h60, nb1: 4'd4};

    rst = 1'b1;
    bus.seed_load = 1'b0; bus.seed = 8'h00;
    bus.ct_valid = 1'b1; bus.ct_bit = 1'b1; bus.ct_last = 1'b0;
    bus.pt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("idle_ct_ready", {31'd0, bus.ct_ready}, 32'd0);
      chk("idle_pt_valid", {31'd0, bus.pt_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check_zero("idle_no_seed");
    bus.ct_valid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].seed, vecs[v].ctv, vecs[v].len, 0, 0, "table");
      exp_q.delete();
      exp_q.push_back('{b: vecs[v].b0, nb: vecs[v].nb0, last: vecs[v].nout == 1});
      if (vecs[v].nout == 2) exp_q.push_back('{b: vecs[v].b1, nb: vecs[v].nb1, last: 1'b1});
      compare_q("table");
    end

    run_frame(8'hFF, 32'hB76E0000, 16, 1, 0, "stall");
    exp_q.delete();
    exp_q.push_back('{b: 8'h48, nb: 4'd8, last: 1'b0});
    exp_q.push_back('{b: 8'h65, nb: 4'd8, last: 1'b1});
    compare_q("stall");

    // Mid-byte reseed: the concurrent bit is dropped and byte alignment restarts.
    bus.seed_load = 1'b1; bus.seed = 8'hFF;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    feed_bits(32'hB7000000, 4);
    run_frame(8'hFF, 32'hB7000000, 8, 0, 0, "reseed");
    exp_q.delete();
    exp_q.push_back('{b: 8'h48, nb: 4'd8, last: 1'b1});
    compare_q("reseed");

    // Reseed discards a byte still waiting for pt_ready.
    bus.seed_load = 1'b1; bus.seed = 8'hFF;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    bus.pt_ready  = 1'b0;
    feed_bits(32'hB7000000, 8);
    chk("pending_valid", {31'd0, bus.pt_valid}, 32'd1);
    chk("pending_byte", {24'd0, bus.pt_byte}, 32'h48);
    bus.seed_load = 1'b1; bus.seed = 8'h5A;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    chk("discard_valid", {31'd0, bus.pt_valid}, 32'd0);
    bus.pt_ready = 1'b1;

    // Reset mid-frame wipes everything, including a sticky seed_err.
    bus.seed_load = 1'b1; bus.seed = 8'h00;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    feed_bits(32'hFFFF0000, 11);
    rst = 1'b1; bus.ct_valid = 1'b1; bus.seed_load = 1'b1;
    @(negedge clk);
    chk("rst_ct_ready", {31'd0, bus.ct_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.seed_load = 1'b0; bus.ct_valid = 1'b0;
    check_zero("rst_mid");

    for (int f = 0; f < 30; f++) begin
      logic [7:0]  sd;
      logic [31:0] ctv;
      int          len;
      sd  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      ctv = $urandom;
      len = $urandom_range(1, 24);
      run_frame(sd, ctv, len, 2, 1, "rand");
      model(sd, ctv, len);
      compare_q("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/otp_decoder.md
OTP_DECODER -- requirements
Module: otp_decoder

Interface
REQ-001 SHALL have parameter TAPS, default 8'hB8, feedback tap mask of the 8-bit keystream LFSR (taps at bits 7,5,4,3).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seed_load  input  1  load seed into LFSR and start a new frame.
REQ-005 SHALL have port seed  input  8  LFSR seed, sampled when seed_load=1.
REQ-006 SHALL have port ct_valid  input  1  ciphertext bit present.
REQ-007 SHALL have port ct_bit  input  1  ciphertext bit, MSB of each byte first.
REQ-008 SHALL have port ct_last  input  1  marks final ciphertext bit of the frame; qualified by ct_valid.
REQ-009 SHALL have port ct_ready  output  1  decoder accepts ct_bit this cycle.
REQ-010 SHALL have port pt_byte  output  8  decoded plaintext byte.
REQ-011 SHALL have port pt_nbits  output  4  valid bits in pt_byte (1..8), left-aligned.
REQ-012 SHALL have port pt_last  output  1  pt_byte is the final byte of the frame.
REQ-013 SHALL have port pt_valid  output  1  pt_byte/pt_nbits/pt_last valid.
REQ-014 SHALL have port pt_ready  input  1  downstream accepts pt_byte.
REQ-015 SHALL have port seed_err  output  1  last seed was all-zero and was substituted.

Function
REQ-016 SHALL implement states IDLE and RUN: IDLE -> RUN on seed_load; RUN -> IDLE on acceptance of a bit with ct_last=1; seed_load in any state -> RUN.
REQ-017 SHALL accept a bit only when ct_valid && ct_ready.
REQ-018 SHALL drive ct_ready = (state==RUN) && !seed_load && (!pt_valid || pt_ready); combinational path from pt_ready is permitted.
REQ-019 SHALL decode each accepted bit as p = ct_bit ^ lfsr[7], then advance the LFSR to {lfsr[6:0], ^(lfsr & TAPS)}; the LFSR SHALL NOT advance on cycles without acceptance.
REQ-020 SHALL assemble p into a shift register MSB-first with a 3-bit bit counter (0..7, wraps to 0 after a byte).
REQ-021 SHALL, on acceptance of the 8th bit, or of any bit with ct_last=1, load pt_byte (partial bytes left-aligned, low bits zero), pt_nbits = bits collected, pt_last = ct_last; pt_valid SHALL assert the next cycle (1-cycle latency).
REQ-022 SHALL hold pt_byte/pt_nbits/pt_last stable while pt_valid && !pt_ready; pt_valid SHALL clear after a pt_valid && pt_ready cycle unless a new byte is loaded in the same cycle.
REQ-023 SHALL, on seed_load, load LFSR with seed, clear shift register and bit counter, clear pt_valid (pending byte discarded), and set seed_err = (seed==8'h00).
REQ-024 SHALL substitute 8'h01 for an all-zero seed to avoid LFSR lock-up.
REQ-025 SHALL give seed_load priority over a simultaneous ct_valid; that bit is not accepted.
REQ-026 SHALL hold seed_err until the next seed_load or rst.
REQ-027 SHALL keep ct_ready low in IDLE regardless of ct_valid.

Reset
REQ-028 SHALL, while rst=1, set state IDLE, LFSR 8'h00, counter 0, shift register 0, pt_byte 8'h00, pt_nbits 0, pt_last 0, pt_valid 0, seed_err 0, ct_ready 0.
REQ-029 SHALL give rst priority over seed_load and all handshakes; rst mid-frame discards all partial and pending data.

Verification
REQ-030 SHALL cover: rst then ct_valid=1 with no seed_load -> ct_ready=0, pt_valid never asserts, all outputs zero.
REQ-031 SHALL cover: seed_load seed=8'hFF, ct bytes 8'hB7, 8'h6E MSB-first, ct_last on 16th bit, pt_ready=1 -> pt_byte 8'h48 then 8'h65, pt_nbits 8, pt_last on second only, state IDLE after.
REQ-032 SHALL cover: same as REQ-031 with pt_ready=0 for 10 cycles after first pt_valid -> ct_ready=0 during stall, 8'h48 held stable, no bit lost, second byte 8'h65.
REQ-033 SHALL cover: seed 8'hFF, ct bits 0,1,0 with ct_last on third -> pt_byte 8'hA0, pt_nbits 3, pt_last=1.
REQ-034 SHALL cover: seed 8'h00 -> seed_err=1; ct byte 8'h49 -> pt_byte 8'h48.
REQ-035 SHALL cover: seed 8'hFF, 4 bits accepted, then seed_load seed=8'hFF concurrent with ct_valid -> bit not accepted, counter 0; re-feed 8'hB7 -> pt_byte 8'h48.
